// File: rtl/hedios_pkg.sv
// Shared Hedios definitions: command codes, packet payload and TX arbiter state encoding.
package hedios_pkg;

  localparam logic [7:0] HDC_RESP   = 8'h01;
  localparam logic [7:0] HDC_LOG    = 8'h02;
  localparam logic [7:0] HDC_DONE   = 8'h03;
  localparam logic [7:0] HDC_ACTION = 8'h04;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [31:0] data;
  } hedios_packet_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_PUSH   = 2'd1,
    ARB_SETTLE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/hedios_rr_picker.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module hedios_rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [NUM_REQ-1:0] w_rot;
  logic [IDX_W-1:0]   w_off;
  int unsigned        w_base;

  // Rotate so the slot after 'last' sits at bit 0, find lowest set bit, then rotate back.
  always_comb begin
    w_base = (32'(last) + 32'd1) % NUM_REQ;
    w_rot  = '0;
    w_off  = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rot[i] = req[IDX_W'((32'(i) + w_base) % NUM_REQ)];
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        found = 1'b1;
        w_off = IDX_W'(i);
      end
    end
    idx = IDX_W'((32'(w_off) + w_base) % NUM_REQ);
  end

endmodule

// File: rtl/hedios_tx_arbiter.sv
// Round-robin arbiter feeding the single Hedios TX packet FIFO from NUM_REQ sources.
// Define HEDIOS_TX_ARB_PRIO0_EN to give source 0 strict priority over the round-robin ring.
module hedios_tx_arbiter
  import hedios_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0][7:0]  req_command,
  input  logic [NUM_REQ-1:0][31:0] req_data,
  output logic [NUM_REQ-1:0]       ack,
  input  logic                     tx_full,
  output logic [7:0]               tx_command,
  output logic [31:0]              tx_data,
  output logic                     tx_push_packet,
  output logic [IDX_W-1:0]         grant_idx,
  output logic                     busy
);

  arb_state_t         r_state;
  arb_state_t         w_next_state;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   r_grant;
  hedios_packet_t     r_pkt;
  logic               r_push;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_busy;

  logic [NUM_REQ-1:0] w_rr_req;
  logic               w_rr_found;
  logic [IDX_W-1:0]   w_rr_idx;
  logic               w_found;
  logic [IDX_W-1:0]   w_win;
  logic               w_upd_last;
  logic               w_take;
  logic               w_push_d;
  logic [NUM_REQ-1:0] w_ack_d;
  logic               w_busy_d;

  hedios_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req   (w_rr_req),
    .last  (r_last),
    .found (w_rr_found),
    .idx   (w_rr_idx)
  );

`ifdef HEDIOS_TX_ARB_PRIO0_EN
  // Source 0 pre-empts the ring; the ring pointer only moves on grants to sources 1..N-1.
  always_comb begin
    w_rr_req   = req & ~NUM_REQ'(1);
    w_found    = req[0] | w_rr_found;
    w_win      = req[0] ? '0 : w_rr_idx;
    w_upd_last = ~req[0];
  end
`else
  always_comb begin
    w_rr_req   = req;
    w_found    = w_rr_found;
    w_win      = w_rr_idx;
    w_upd_last = 1'b1;
  end
`endif

  assign w_take = (r_state == ARB_IDLE) && w_found && !tx_full;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ARB_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE:   if (w_take) w_next_state = ARB_PUSH;
      ARB_PUSH:   w_next_state = ARB_SETTLE;
      ARB_SETTLE: w_next_state = ARB_IDLE;
      default:    w_next_state = ARB_IDLE;
    endcase
  end

  // Busy spans the latch decision through the settle cycle of the registered outputs.
  always_comb begin
    w_push_d = 1'b0;
    w_ack_d  = '0;
    w_busy_d = (r_state != ARB_IDLE) || (w_next_state != ARB_IDLE);
    if (r_state == ARB_PUSH) begin
      w_push_d = 1'b1;
      w_ack_d  = NUM_REQ'(1) << r_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_push <= 1'b0;
      r_ack  <= '0;
      r_busy <= 1'b0;
    end else begin
      r_push <= w_push_d;
      r_ack  <= w_ack_d;
      r_busy <= w_busy_d;
    end
  end

  // Packet is captured only on the IDLE decision; later req_* changes cannot reach the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt   <= '0;
      r_grant <= '0;
      r_last  <= IDX_W'(NUM_REQ - 1);
    end else if (w_take) begin
      r_pkt.cmd  <= req_command[w_win];
      r_pkt.data <= req_data[w_win];
      r_grant    <= w_win;
      if (w_upd_last) r_last <= w_win;
    end
  end

  assign tx_command     = r_pkt.cmd;
  assign tx_data        = r_pkt.data;
  assign tx_push_packet = r_push;
  assign ack            = r_ack;
  assign grant_idx      = r_grant;
  assign busy           = r_busy;

endmodule

// File: tb/tb_hedios_tx_arbiter.sv
// Self-checking bench for hedios_tx_arbiter: directed table, corner sequences, random vs. model.
module tb_hedios_tx_arbiter;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req = '0;
  logic [N-1:0][7:0] req_command = '0;
  logic [N-1:0][31:0] req_data = '0;
  logic [N-1:0]      ack;
  logic              tx_full = 1'b0;
  logic [7:0]        tx_command;
  logic [31:0]       tx_data;
  logic              tx_push_packet;
  logic [1:0]        grant_idx;
  logic              busy;

  hedios_tx_arbiter #(.NUM_REQ(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_command    (req_command),
    .req_data       (req_data),
    .ack            (ack),
    .tx_full        (tx_full),
    .tx_command     (tx_command),
    .tx_data        (tx_data),
    .tx_push_packet (tx_push_packet),
    .grant_idx      (grant_idx),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  s_cmd  [N];
  logic [31:0] s_data [N];

  typedef struct {
    logic [N-1:0] req;
    logic         full;
    logic         exp_push;
    int           exp_idx;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic [N-1:0] r, input logic full);
    req     = r;
    tx_full = full;
    for (int i = 0; i < N; i++) begin
      req_command[i] = s_cmd[i];
      req_data[i]    = s_data[i];
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_push"}, 64'(tx_push_packet), 64'd0);
    chk({name, "_ack"},  64'(ack),            64'd0);
    chk({name, "_busy"}, 64'(busy),           64'd0);
    chk({name, "_cmd"},  64'(tx_command),     64'd0);
    chk({name, "_data"}, 64'(tx_data),        64'd0);
    chk({name, "_idx"},  64'(grant_idx),      64'd0);
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    drive('0, 1'b0);
    next_cycle();
    mid();
    chk_all_zero("reset");
    rst = 1'b0;
  endtask

  // Reference winner: first requester scanning upward from last+1, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int last);
    int j;
`ifdef HEDIOS_TX_ARB_PRIO0_EN
    if (r[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      j = (last + k) % N;
`ifdef HEDIOS_TX_ARB_PRIO0_EN
      if (j != 0 && ((r >> j) & 1) != 0) return j;
`else
      if (((r >> j) & 1) != 0) return j;
`endif
    end
    return -1;
  endfunction

  initial begin
    logic prev_push;
    int   seq [6];
    int   m_last, m_next_ok, m_push_cyc, m_push_idx, m_idx, m_busy_from, m_busy_to;
    int   w, max_wait;
    int   waitc [N];
    logic [7:0]  m_cmd;
    logic [31:0] m_data;
    logic        ackd [N];
    logic [N-1:0] s_req;
    logic         e_push;

    tbl[0] = '{4'b0001, 1'b0, 1'b1, 0};
`ifdef HEDIOS_TX_ARB_PRIO0_EN
    tbl[1] = '{4'b1111, 1'b0, 1'b1, 0};
    tbl[2] = '{4'b1111, 1'b0, 1'b1, 0};
    tbl[3] = '{4'b1111, 1'b0, 1'b1, 0};
    tbl[4] = '{4'b1111, 1'b0, 1'b1, 0};
    tbl[5] = '{4'b0100, 1'b1, 1'b0, 0};
    tbl[6] = '{4'b1001, 1'b0, 1'b1, 0};
    tbl[7] = '{4'b1001, 1'b0, 1'b1, 0};
    seq = '{0, 0, 0, 1, 2, 3};
`else
    tbl[1] = '{4'b1111, 1'b0, 1'b1, 1};
    tbl[2] = '{4'b1111, 1'b0, 1'b1, 2};
    tbl[3] = '{4'b1111, 1'b0, 1'b1, 3};
    tbl[4] = '{4'b1111, 1'b0, 1'b1, 0};
    tbl[5] = '{4'b0100, 1'b1, 1'b0, 0};
    tbl[6] = '{4'b1001, 1'b0, 1'b1, 3};
    tbl[7] = '{4'b1001, 1'b0, 1'b1, 0};
    seq = '{0, 1, 2, 3, 0, 1};
`endif
    tbl[8] = '{4'b0000, 1'b0, 1'b0, 0};
    tbl[9] = '{4'b0110, 1'b0, 1'b1, 1};

    s_cmd[0] = 8'h04; s_data[0] = 32'hDEADBEEF;
    for (int i = 1; i < N; i++) begin
      s_cmd[i]  = 8'h10 + 8'(i);
      s_data[i] = 32'hA000_0000 + 32'(i);
    end

    do_reset();

    // Directed table: decision cycle, then two cycles to the strobe.
    prev_push = 1'b0;
    for (int e = 0; e < 10; e++) begin
      next_cycle();
      drive(tbl[e].req, tbl[e].full);
      mid();
      chk("tbl_a_push", 64'(tx_push_packet), 64'd0);
      chk("tbl_a_busy", 64'(busy), 64'(prev_push));
      next_cycle();
      drive('0, 1'b0);
      mid();
      chk("tbl_b_push", 64'(tx_push_packet), 64'd0);
      chk("tbl_b_busy", 64'(busy), 64'(tbl[e].exp_push));
      next_cycle();
      mid();
      chk("tbl_c_push", 64'(tx_push_packet), 64'(tbl[e].exp_push));
      chk("tbl_c_ack", 64'(ack), tbl[e].exp_push ? 64'(4'b0001 << tbl[e].exp_idx) : 64'd0);
      chk("tbl_c_idx", 64'(grant_idx), 64'(tbl[e].exp_idx));
      chk("tbl_c_busy", 64'(busy), 64'(tbl[e].exp_push));
      if (tbl[e].exp_push) begin
        chk("tbl_c_cmd",  64'(tx_command), 64'(s_cmd[tbl[e].exp_idx]));
        chk("tbl_c_data", 64'(tx_data),    64'(s_data[tbl[e].exp_idx]));
      end
      prev_push = tbl[e].exp_push;
    end

    // tx_full held for 10 cycles blocks the grant; push lands 2 cycles after release.
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      drive(4'b0100, 1'b1);
      mid();
      chk("full_push", 64'(tx_push_packet), 64'd0);
      chk("full_ack", 64'(ack), 64'd0);
    end
    next_cycle(); drive(4'b0100, 1'b0); mid();
    chk("rel_push0", 64'(tx_push_packet), 64'd0);
    next_cycle(); mid();
    chk("rel_push1", 64'(tx_push_packet), 64'd0);
    next_cycle(); mid();
    chk("rel_push2", 64'(tx_push_packet), 64'd1);
    chk("rel_ack", 64'(ack), 64'(4'b0100));
    chk("rel_idx", 64'(grant_idx), 64'd2);

    // Data changed after latch must not reach the FIFO.
    s_cmd[2] = 8'h22; s_data[2] = 32'h1111_2222;
    next_cycle(); drive(4'b0100, 1'b0); mid();
    s_cmd[2] = 8'h33; s_data[2] = 32'h3333_4444;
    next_cycle(); drive(4'b0100, 1'b0); mid();
    next_cycle(); mid();
    chk("late_push", 64'(tx_push_packet), 64'd1);
    chk("late_data", 64'(tx_data), 64'h1111_2222);
    chk("late_cmd", 64'(tx_command), 64'h22);

    // All requesting: a strobe every third cycle in ring order (source 0 pinned in prio mode).
    do_reset();
    for (int c = 0; c < 18; c++) begin
      next_cycle();
`ifdef HEDIOS_TX_ARB_PRIO0_EN
      drive((c >= 9) ? 4'b1110 : 4'b1111, 1'b0);
`else
      drive(4'b1111, 1'b0);
`endif
      mid();
      e_push = (c % 3 == 2);
      chk("ring_push", 64'(tx_push_packet), 64'(e_push));
      chk("ring_ack", 64'(ack), e_push ? 64'(4'b0001 << seq[c / 3]) : 64'd0);
      if (e_push) chk("ring_idx", 64'(grant_idx), 64'(seq[c / 3]));
    end

    // Reset while source 1 is in PUSH abandons it; next grant restarts at source 0.
    next_cycle(); drive(4'b0010, 1'b0); mid();
    next_cycle(); rst = 1'b1; mid();
    next_cycle(); rst = 1'b0; drive(4'b0011, 1'b0); mid();
    chk_all_zero("rstpush");
    next_cycle(); mid();
    chk("rstpush_p1", 64'(tx_push_packet), 64'd0);
    next_cycle(); mid();
    chk("rstpush_p2", 64'(tx_push_packet), 64'd1);
    chk("rstpush_ack", 64'(ack), 64'(4'b0001));
    chk("rstpush_idx", 64'(grant_idx), 64'd0);

    // Randomised traffic against the timeline model.
    do_reset();
    m_last = N - 1; m_next_ok = 0; m_push_cyc = -10; m_push_idx = 0;
    m_idx = 0; m_cmd = '0; m_data = '0; m_busy_from = 1; m_busy_to = 0;
    max_wait = 0;
    s_req = '0;
    for (int i = 0; i < N; i++) begin
      ackd[i] = 1'b0;
      waitc[i] = 0;
    end
    for (int c = 0; c < 600; c++) begin
      next_cycle();
      for (int i = 0; i < N; i++) begin
        if (ackd[i] || (!s_req[i] && $urandom_range(0, 3) == 0)) begin
          s_req[i] = ackd[i] ? 1'($urandom_range(0, 1)) : 1'b1;
          s_cmd[i] = 8'($urandom);
          s_data[i] = $urandom;
          ackd[i] = 1'b0;
        end
      end
      drive(s_req, $urandom_range(0, 3) == 0);
      mid();
      e_push = (c == m_push_cyc);
      chk("rnd_push", 64'(tx_push_packet), 64'(e_push));
      chk("rnd_ack", 64'(ack), e_push ? 64'(4'b0001 << m_push_idx) : 64'd0);
      chk("rnd_busy", 64'(busy), 64'(c >= m_busy_from && c <= m_busy_to));
      chk("rnd_idx", 64'(grant_idx), 64'(m_idx));
      chk("rnd_cmd", 64'(tx_command), 64'(m_cmd));
      chk("rnd_data", 64'(tx_data), 64'(m_data));
      if (e_push) ackd[m_push_idx] = 1'b1;
      if (c >= m_next_ok && req != '0 && !tx_full) begin
        w = pick(req, m_last);
        m_cmd = s_cmd[w]; m_data = s_data[w]; m_idx = w;
`ifdef HEDIOS_TX_ARB_PRIO0_EN
        if (w != 0) m_last = w;
`else
        m_last = w;
`endif
        for (int i = 0; i < N; i++) begin
          if (i == w) waitc[i] = 0;
          else if (req[i]) waitc[i]++;
          if (waitc[i] > max_wait) max_wait = waitc[i];
        end
        m_push_cyc = c + 2; m_push_idx = w; m_next_ok = c + 3;
        if (m_busy_to < c) m_busy_from = c + 1;
        m_busy_to = c + 3;
      end
    end
`ifndef HEDIOS_TX_ARB_PRIO0_EN
    chk("rnd_maxwait_ok", 64'(max_wait <= N - 1), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
